// File: rtl/ss2_arb_pkg.sv
// Shared types and constants for the two-requester SS2 register-bus arbiter.
package ss2_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } arb_state_e;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  // Wide enough for the largest legal strobe length (15).
  localparam int unsigned STRB_CNT_W = 4;

endpackage

// File: rtl/ss2_arb_bus_seq.sv
// SETUP/STROBE/HOLD bus timing sequencer; all bus control outputs are registered.
module ss2_arb_bus_seq
  import ss2_arb_pkg::*;
#(
  parameter int unsigned pSTROBE_CYCLES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic start_i,
  input  logic wr_i,
  output logic busy_o,
  output logic bus_cen_o,
  output logic bus_rdn_o,
  output logic bus_wrn_o,
  output logic strobe_done_c_o
);

  arb_state_e            state_q, state_d;
  logic [STRB_CNT_W-1:0] cnt_q, cnt_d;
  logic                  busy_q, cen_q, rdn_q, wrn_q;

  // Counter holds the number of strobe cycles still to go after the current one.
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    strobe_done_c_o = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_i) state_d = SETUP;
      end
      SETUP: begin
        state_d = STROBE;
        cnt_d   = STRB_CNT_W'(pSTROBE_CYCLES - 1);
      end
      STROBE: begin
        if (cnt_q == '0) begin
          state_d         = HOLD;
          strobe_done_c_o = 1'b1;
        end else begin
          cnt_d = cnt_q - STRB_CNT_W'(1);
        end
      end
      HOLD: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state so they change on the same edge as the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      cen_q   <= 1'b1;
      rdn_q   <= 1'b1;
      wrn_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= (state_d != IDLE);
      cen_q   <= !((state_d == SETUP) || (state_d == STROBE));
      rdn_q   <= !((state_d == STROBE) && !wr_i);
      wrn_q   <= !((state_d == STROBE) && wr_i);
    end
  end

  assign busy_o    = busy_q;
  assign bus_cen_o = cen_q;
  assign bus_rdn_o = rdn_q;
  assign bus_wrn_o = wrn_q;

endmodule

// File: rtl/ss2_bus_arbiter.sv
// Round-robin arbiter sharing one 8-bit register bus between two requesters.
// Define SS2_ARB_LOCK_EN to let the owner keep the grant while its lock is high at HOLD.
module ss2_bus_arbiter
  import ss2_arb_pkg::*;
#(
  parameter int unsigned pADDR_WIDTH    = 32,
  parameter int unsigned pSTROBE_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   r0_req,
  input  logic                   r0_wr,
  input  logic [pADDR_WIDTH-1:0] r0_addr,
  input  logic [7:0]             r0_wdata,
  input  logic                   r0_lock,
  output logic                   r0_ack,
  output logic [7:0]             r0_rdata,
  input  logic                   r1_req,
  input  logic                   r1_wr,
  input  logic [pADDR_WIDTH-1:0] r1_addr,
  input  logic [7:0]             r1_wdata,
  input  logic                   r1_lock,
  output logic                   r1_ack,
  output logic [7:0]             r1_rdata,
  output logic [pADDR_WIDTH-1:0] bus_addr,
  output logic [7:0]             bus_wdata,
  input  logic [7:0]             bus_rdata,
  output logic                   bus_cen,
  output logic                   bus_rdn,
  output logic                   bus_wrn,
  output logic                   busy,
  output logic                   owner
);

`ifdef SS2_ARB_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic                   start_c, win_c, strobe_done_c, hold_c;
  logic                   owner_q, lock_q, wr_q, ack0_q, ack1_q;
  logic [pADDR_WIDTH-1:0] addr_q;
  logic [7:0]             wdata_q, rdata0_q, rdata1_q;

  // Arbitration only while the sequencer is idle; lock overrides round-robin on a tie.
  always_comb begin
    start_c = 1'b0;
    win_c   = owner_q;
    if (!busy && (r0_req || r1_req)) begin
      start_c = 1'b1;
      if (r0_req && r1_req) win_c = (LOCK_EN && lock_q) ? owner_q : !owner_q;
      else                  win_c = r1_req ? REQ1 : REQ0;
    end
  end

  assign hold_c = ack0_q | ack1_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      owner_q  <= REQ1;
      lock_q   <= 1'b0;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
    end else begin
      if (start_c) begin
        owner_q <= win_c;
        wr_q    <= (win_c == REQ1) ? r1_wr    : r0_wr;
        addr_q  <= (win_c == REQ1) ? r1_addr  : r0_addr;
        wdata_q <= (win_c == REQ1) ? r1_wdata : r0_wdata;
      end
      ack0_q <= strobe_done_c && (owner_q == REQ0);
      ack1_q <= strobe_done_c && (owner_q == REQ1);
      if (strobe_done_c && !wr_q) begin
        if (owner_q == REQ1) rdata1_q <= bus_rdata;
        else                 rdata0_q <= bus_rdata;
      end
      if (hold_c) lock_q <= LOCK_EN && ((owner_q == REQ1) ? r1_lock : r0_lock);
    end
  end

  ss2_arb_bus_seq #(
    .pSTROBE_CYCLES(pSTROBE_CYCLES)
  ) u_seq (
    .clk            (clk),
    .reset          (reset),
    .start_i        (start_c),
    .wr_i           (wr_q),
    .busy_o         (busy),
    .bus_cen_o      (bus_cen),
    .bus_rdn_o      (bus_rdn),
    .bus_wrn_o      (bus_wrn),
    .strobe_done_c_o(strobe_done_c)
  );

  assign owner     = owner_q;
  assign bus_addr  = addr_q;
  assign bus_wdata = wdata_q;
  assign r0_ack    = ack0_q;
  assign r1_ack    = ack1_q;
  assign r0_rdata  = rdata0_q;
  assign r1_rdata  = rdata1_q;

endmodule

// File: doc/ss2_bus_arbiter.md
SS2_BUS_ARBITER -- requirements
Module: ss2_bus_arbiter

Interface
REQ-001 Parameter pADDR_WIDTH, default 32, width of requester and bus address.
REQ-002 Parameter pSTROBE_CYCLES, default 2, cycles rdn/wrn held low per access; legal range 1..15.
REQ-003 The block SHALL use one clock and a synchronous, active-high reset, named as follows.
- clk  in  1  sole clock.
- reset  in  1  synchronous active-high reset.
REQ-004 Each requester n (n=0,1) SHALL have the following ports.
- rN_req  in  1  transaction request, level.
- rN_wr  in  1  1=write, 0=read.
- rN_addr  in  pADDR_WIDTH  address.
- rN_wdata  in  8  write data.
- rN_lock  in  1  keep grant for next transaction.
- rN_ack  out  1  one-cycle completion pulse.
- rN_rdata  out  8  read data.
REQ-005 The DUT register bus SHALL use the following ports.
- bus_addr  out  pADDR_WIDTH  address.
- bus_wdata  out  8  write data.
- bus_rdata  in  8  read data.
- bus_cen  out  1  chip enable, active-low.
- bus_rdn  out  1  read strobe, active-low.
- bus_wrn  out  1  write strobe, active-low.
- busy  out  1  high when the FSM is not IDLE.
- owner  out  1  index of the last or current granted requester.

Function
REQ-006 FSM states SHALL be IDLE, SETUP, STROBE and HOLD.
REQ-007 In IDLE with any rN_req high, the FSM SHALL latch the winner's wr/addr/wdata and enter SETUP on the next edge.
REQ-008 Arbitration SHALL be round-robin: if both request, the requester not equal to owner wins; a single requester always wins.
REQ-009 SETUP SHALL last 1 cycle with bus_cen=0 and strobes high; STROBE SHALL last exactly pSTROBE_CYCLES cycles with bus_cen=0 and bus_wrn=0 (write) or bus_rdn=0 (read).
REQ-010 For reads, bus_rdata SHALL be captured on the clock edge ending the last STROBE cycle.
REQ-011 HOLD SHALL last 1 cycle with bus_cen=1 and both strobes high, and SHALL assert the winner's rN_ack; the FSM SHALL return to IDLE next.
REQ-012 Latency: req seen in IDLE at cycle 0 SHALL give ack at cycle 2+pSTROBE_CYCLES; minimum back-to-back period SHALL be 3+pSTROBE_CYCLES cycles.
REQ-013 rN_rdata SHALL update only on completion of that requester's read, and SHALL hold its value otherwise, including across writes and across the other requester's transactions.
REQ-014 bus_addr and bus_wdata SHALL be stable from SETUP through HOLD; requester inputs changing after latch SHALL have no effect on that access.
REQ-015 Requesters SHALL hold req and their fields until ack; req still high in the cycle after ack SHALL be treated as a new request.
REQ-016 Strobes SHALL never be low outside STROBE; rdn and wrn SHALL never be low simultaneously.

Reset
REQ-017 On reset the FSM SHALL enter IDLE with bus_cen=1, bus_rdn=1, bus_wrn=1, bus_addr=0, bus_wdata=0, rN_ack=0, rN_rdata=0, busy=0 and owner=1, so r0 wins the first tie.
REQ-018 Reset asserted mid-access SHALL deassert all strobes and cen on the next edge, issue no ack, and discard the access.

Configuration
REQ-019 With macro SS2_ARB_LOCK_EN defined, if the owner's rN_lock is high during HOLD, the next arbitration SHALL grant that owner whenever it requests; the other requester SHALL wait until lock is low at a HOLD.
REQ-020 Without SS2_ARB_LOCK_EN, the rN_lock ports SHALL exist but be ignored, and arbitration SHALL be pure round-robin.

Structure
REQ-021 Shared package ss2_arb_pkg SHALL hold the state enumeration, requester index constants (REQ0=0, REQ1=1) and the strobe counter width.
REQ-022 The SETUP/STROBE/HOLD timing SHALL be a sub-module, ss2_arb_bus_seq; arbitration, latching and rdata routing SHALL live in the top module.

Verification
REQ-023 The bench SHALL cover the following directed scenarios.
- Single read: r0 reads 0x0000_0010, bus_rdata=0xA5 during strobe, pSTROBE_CYCLES=2 -> rdn low exactly 2 cycles, r0_ack at cycle 4, r0_rdata=0xA5, r1_rdata unchanged at 0.
- Tie after reset: r0 and r1 request together -> r0 served first, then r1; owner ends at 1; no cycle has both strobes low.
- Continuous contention: both hold req for 6 transactions -> grants alternate r0,r1,r0,r1,r0,r1, with 5-cycle period at pSTROBE_CYCLES=2.
- Write: r1 writes 0x3C to 0x0000_0200 while changing r1_addr after latch -> bus shows 0x200/0x3C throughout, wrn low 2 cycles.
- Reset mid-access: reset during the 1st STROBE cycle -> next cycle cen=rdn=wrn=1, no ack, busy=0.
- Lock (SS2_ARB_LOCK_EN): r0 holds lock for 3 writes with r1 requesting -> r0 gets 3 consecutive grants, then r1; without the macro, grants alternate.
